// File: rtl/branch_predictor.sv
// Next-PC predictor for fetch: direct-mapped BTB plus gshare PHT, trained by
// resolved control flow in EX, which also produces the misprediction redirect.
module branch_predictor #(
    parameter int unsigned INDEX_BITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           if_pc,
    output logic                  pred_taken,
    output logic [31:0]           pred_next_pc,
    output logic [INDEX_BITS-1:0] if_ghr,
    input  logic                  ex_valid,
    input  logic                  ex_is_ctrl,
    input  logic                  ex_taken,
    input  logic [31:0]           ex_pc,
    input  logic [31:0]           ex_target,
    input  logic [31:0]           ex_pred_pc,
    input  logic [INDEX_BITS-1:0] ex_ghr,
    output logic                  mispredict,
    output logic [31:0]           correct_pc,
    output logic [31:0]           mispredict_count
);

    localparam int unsigned ENTRIES  = 1 << INDEX_BITS;
    localparam int unsigned TAG_BITS = 30 - INDEX_BITS;

    logic                  btb_valid  [ENTRIES];
    logic [TAG_BITS-1:0]   btb_tag    [ENTRIES];
    logic [31:0]           btb_target [ENTRIES];
    logic [1:0]            pht        [ENTRIES];
    logic [INDEX_BITS-1:0] ghr;

    logic [INDEX_BITS-1:0] if_idx;
    logic [TAG_BITS-1:0]   if_tag;
    logic [INDEX_BITS-1:0] if_pht_idx;
    logic                  if_hit;
    logic [INDEX_BITS-1:0] ex_idx;
    logic [TAG_BITS-1:0]   ex_tag;
    logic [INDEX_BITS-1:0] ex_pht_idx;
    logic                  ex_hit;
    logic                  ex_redirect;
    logic [31:0]           actual_next;
    logic                  unused_pc_bits;

    assign if_idx     = if_pc[INDEX_BITS+1:2];
    assign if_tag     = if_pc[31:INDEX_BITS+2];
    assign if_pht_idx = if_idx ^ ghr;
    assign ex_idx     = ex_pc[INDEX_BITS+1:2];
    assign ex_tag     = ex_pc[31:INDEX_BITS+2];
    assign ex_pht_idx = ex_idx ^ ex_ghr;
    assign if_ghr     = ghr;

    // Instruction addresses are word aligned; the byte offset never selects anything.
    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

    // Fetch-side lookup
    always_comb begin
        if_hit       = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
        pred_taken   = if_hit && pht[if_pht_idx][1];
        pred_next_pc = pred_taken ? btb_target[if_idx] : if_pc + 32'd4;
    end

    // EX-side resolution
    always_comb begin
        ex_hit      = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);
        ex_redirect = ex_is_ctrl && ex_taken;
        actual_next = ex_redirect ? ex_target : ex_pc + 32'd4;
        mispredict  = ex_valid && (actual_next != ex_pred_pc);
        correct_pc  = actual_next;
    end

    // Valid bits, counters, history and statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                btb_valid[i] <= 1'b0;
                pht[i]       <= 2'b01;
            end
            ghr              <= '0;
            mispredict_count <= '0;
        end else if (ex_valid) begin
            if (ex_is_ctrl) begin
                if (ex_taken && (pht[ex_pht_idx] != 2'b11)) begin
                    pht[ex_pht_idx] <= pht[ex_pht_idx] + 2'd1;
                end else if (!ex_taken && (pht[ex_pht_idx] != 2'b00)) begin
                    pht[ex_pht_idx] <= pht[ex_pht_idx] - 2'd1;
                end
                ghr <= {ghr[INDEX_BITS-2:0], ex_taken};
                if (ex_taken) begin
                    btb_valid[ex_idx] <= 1'b1;
                end
            end else if (ex_hit) begin
                // A non-control instruction hit the BTB: drop the aliased entry.
                btb_valid[ex_idx] <= 1'b0;
            end
            if (mispredict) begin
                mispredict_count <= mispredict_count + 32'd1;
            end
        end
    end

    // Tag and target payload only matter while the valid bit is set.
    always_ff @(posedge clk) begin
        if (!reset && ex_valid && ex_redirect) begin
            btb_tag[ex_idx]    <= ex_tag;
            btb_target[ex_idx] <= ex_target;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized and directed checks of branch_predictor against a behavioural
// model that keeps the full trained PC per slot and integer counters.
module tb_branch_predictor;

    localparam int IB = 5;
    localparam int N  = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   if_pc;
    logic          pred_taken;
    logic [31:0]   pred_next_pc;
    logic [IB-1:0] if_ghr;
    logic          ex_valid;
    logic          ex_is_ctrl;
    logic          ex_taken;
    logic [31:0]   ex_pc;
    logic [31:0]   ex_target;
    logic [31:0]   ex_pred_pc;
    logic [IB-1:0] ex_ghr;
    logic          mispredict;
    logic [31:0]   correct_pc;
    logic [31:0]   mispredict_count;

    always #5 clk = ~clk;

    branch_predictor #(.INDEX_BITS(IB)) dut (
        .clk              (clk),
        .reset            (reset),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_next_pc     (pred_next_pc),
        .if_ghr           (if_ghr),
        .ex_valid         (ex_valid),
        .ex_is_ctrl       (ex_is_ctrl),
        .ex_taken         (ex_taken),
        .ex_pc            (ex_pc),
        .ex_target        (ex_target),
        .ex_pred_pc       (ex_pred_pc),
        .ex_ghr           (ex_ghr),
        .mispredict       (mispredict),
        .correct_pc       (correct_pc),
        .mispredict_count (mispredict_count)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: each slot remembers the whole PC that trained it.
    bit          m_valid [N];
    logic [31:0] m_pc    [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];
    int          m_ghr;
    logic [31:0] m_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'(pc >> 2) & (N - 1);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        int i = idx_of(pc);
        return m_valid[i] && ((m_pc[i] >> (IB + 2)) == (pc >> (IB + 2)));
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[idx_of(pc) ^ m_ghr] >= 2);
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] pc);
        return m_pred(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_ghr = 0;
        m_cnt = '0;
    endtask

    // One clock: drive, check combinational outputs, then advance the model.
    task automatic cycle(input bit rst, input bit v, input bit ctrl, input bit tk,
                         input logic [31:0] ipc, input logic [31:0] epc,
                         input logic [31:0] etgt, input logic [31:0] epred, input int eg);
        logic [31:0] act;
        bit          mis;
        int          p;
        int          i;
        reset      = rst;
        ex_valid   = v;
        ex_is_ctrl = ctrl;
        ex_taken   = tk;
        if_pc      = ipc;
        ex_pc      = epc;
        ex_target  = etgt;
        ex_pred_pc = epred;
        ex_ghr     = IB'(eg);
        #1;
        act = (ctrl && tk) ? etgt : epc + 32'd4;
        mis = v && (act != epred);
        check_eq("pred_taken", 32'(pred_taken), 32'(m_pred(ipc)));
        check_eq("pred_next_pc", pred_next_pc, m_next(ipc));
        check_eq("if_ghr", 32'(if_ghr), 32'(m_ghr));
        check_eq("mispredict", 32'(mispredict), 32'(mis));
        if (mis) check_eq("correct_pc", correct_pc, act);
        check_eq("mispredict_count", mispredict_count, m_cnt);
        @(posedge clk);
        if (rst) begin
            m_reset();
        end else if (v) begin
            if (ctrl) begin
                p = idx_of(epc) ^ (eg & (N - 1));
                if (tk) m_ctr[p] = (m_ctr[p] < 3) ? m_ctr[p] + 1 : 3;
                else    m_ctr[p] = (m_ctr[p] > 0) ? m_ctr[p] - 1 : 0;
                m_ghr = ((m_ghr << 1) | int'(tk)) & (N - 1);
                if (tk) begin
                    i = idx_of(epc);
                    m_valid[i] = 1'b1;
                    m_pc[i]    = epc;
                    m_tgt[i]   = etgt;
                end
            end else if (m_hit(epc)) begin
                m_valid[idx_of(epc)] = 1'b0;
            end
            if (mis) m_cnt = m_cnt + 32'd1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [31:0] ipc);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, ipc, 32'h0, 32'h0, 32'h0, 0);
    endtask

    task automatic train(input bit ctrl, input bit tk, input logic [31:0] epc,
                         input logic [31:0] etgt, input logic [31:0] epred, input int eg);
        cycle(1'b0, 1'b1, ctrl, tk, epc, epc, etgt, epred, eg);
    endtask

    logic [31:0] pool [8];

    initial begin
        reset = 1'b1;
        if_pc = '0; ex_valid = 1'b0; ex_is_ctrl = 1'b0; ex_taken = 1'b0;
        ex_pc = '0; ex_target = '0; ex_pred_pc = '0; ex_ghr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_reset();

        // First training: mispredict and history shift
        idle(32'h100);
        train(1'b1, 1'b1, 32'h100, 32'h80, 32'h104, 0);
        idle(32'h100);
        train(1'b1, 1'b1, 32'h100, 32'h80, 32'h104, 1);
        idle(32'h100);

        // Saturating counter with history returned to zero
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 0, 0, 0, 0);
        train(1'b1, 1'b1, 32'h100, 32'h80, 32'h104, 0);
        train(1'b1, 1'b1, 32'h100, 32'h80, 32'h104, 0);
        repeat (5) train(1'b1, 1'b0, 32'h40, 32'h0, 32'h44, 0);
        idle(32'h100);
        repeat (4) begin
            train(1'b1, 1'b0, 32'h100, 32'h80, 32'h80, 0);
            idle(32'h100);
        end
        train(1'b1, 1'b1, 32'h100, 32'h80, 32'h104, 0);
        idle(32'h100);

        // Aliasing: non-control hit clears the entry; same index, other tag never hits
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 0, 0, 0, 0);
        train(1'b1, 1'b1, 32'h100, 32'h80, 32'h104, 0);
        train(1'b1, 1'b1, 32'h100, 32'h80, 32'h104, 1);
        idle(32'h180);
        train(1'b0, 1'b0, 32'h100, 32'h0, 32'h80, 0);
        idle(32'h100);

        // JALR target change
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h200, 0, 0, 0, 0);
        train(1'b1, 1'b1, 32'h200, 32'h400, 32'h204, 0);
        train(1'b1, 1'b1, 32'h200, 32'h400, 32'h204, 0);
        train(1'b1, 1'b1, 32'h200, 32'h500, 32'h400, 0);
        idle(32'h200);

        // Reset beats a simultaneous taken update
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h300, 32'h300, 32'h999c, 32'h304, 0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h300, 0, 0, 0, 0);
        train(1'b1, 1'b1, 32'h104, 32'h600, 32'h108, 0);
        idle(32'h300);

        // Randomized traffic over a small address pool to force hits and aliasing
        pool[0] = 32'h100; pool[1] = 32'h180; pool[2] = 32'h200; pool[3] = 32'h104;
        pool[4] = 32'h280; pool[5] = 32'h40;  pool[6] = 32'h300;
        for (int k = 0; k < 600; k++) begin
            logic [31:0] ipc, epc, etgt, epred;
            bit          ctrl, tk, v, rst;
            int          eg, r;
            pool[7] = $urandom & 32'hFFFF_FFFC;
            ipc  = pool[$urandom_range(7)];
            epc  = pool[$urandom_range(7)];
            etgt = pool[$urandom_range(7)];
            ctrl = ($urandom_range(3) != 0);
            tk   = ($urandom_range(1) != 0);
            v    = ($urandom_range(4) != 0);
            rst  = ($urandom_range(63) == 0);
            eg   = ($urandom_range(3) != 0) ? m_ghr : int'($urandom_range(N - 1));
            r    = int'($urandom_range(3));
            if (r < 2)       epred = m_next(epc);
            else if (r == 2) epred = (ctrl && tk) ? etgt : epc + 32'd4;
            else             epred = pool[$urandom_range(7)];
            cycle(rst, v, ctrl, tk, ipc, epc, etgt, epred, eg);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor and redirect controller for the pipelined RISC-V core. It predicts the next fetch PC in IF using a direct-mapped BTB and a gshare pattern history table. It trains on branch and jump outcomes resolved in EX, where the branch comparator produces `bcond`. It also detects mispredictions and supplies the corrected PC to the flush/redirect logic.

## Interface
- `INDEX_BITS`, default 5: log2 of BTB/PHT entries (32); BTB index = pc[INDEX_BITS+1:2], tag = pc[31:INDEX_BITS+2]
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `if_pc`  in  32  PC of instruction being fetched
- `pred_taken`  out  1  prediction for `if_pc`
- `pred_next_pc`  out  32  predicted next fetch PC
- `if_ghr`  out  INDEX_BITS  current global history; the pipeline carries it to EX
- `ex_valid`  in  1  EX holds a valid, non-stalled instruction this cycle
- `ex_is_ctrl`  in  1  EX instruction is BRANCH, JAL or JALR
- `ex_taken`  in  1  resolved outcome (`bcond` for branches, 1 for jumps)
- `ex_pc`  in  32  PC of EX instruction
- `ex_target`  in  32  resolved target address
- `ex_pred_pc`  in  32  `pred_next_pc` carried from IF
- `ex_ghr`  in  INDEX_BITS  `if_ghr` carried from IF
- `mispredict`  out  1  EX-stage redirect/flush request
- `correct_pc`  out  32  PC to fetch when `mispredict`=1
- `mispredict_count`  out  32  running count of mispredictions

## Operation
- State:
  - BTB per entry: valid, tag, target.
  - PHT: 2^INDEX_BITS 2-bit saturating counters.
  - GHR: INDEX_BITS bits.
  - `mispredict_count`.
- Lookup (combinational):
  - `hit` = valid[idx(if_pc)] && tag matches.
  - `pred_taken` = `hit` && PHT[idx(if_pc) ^ GHR][1].
  - `pred_next_pc` = `pred_taken` ? BTB target : `if_pc`+4, modulo 2^32.
- Resolution (combinational):
  - `actual_next` = (`ex_is_ctrl` && `ex_taken`) ? `ex_target` : `ex_pc`+4.
  - `mispredict` = `ex_valid` && (`actual_next` != `ex_pred_pc`).
  - `correct_pc` = `actual_next`. It is driven every cycle but only meaningful when `mispredict`=1.
  - A wrong target on a correctly predicted taken jump also counts as a mispredict (JALR target change).
- Update, at the edge where `ex_valid`=1:
  - If `ex_is_ctrl`=1:
    - p = idx(ex_pc) ^ `ex_ghr`. PHT[p] increments when taken, decrements when not taken, saturating at 3 and 0.
    - GHR <= {GHR[INDEX_BITS-2:0], `ex_taken`}.
    - If `ex_taken`=1: BTB[idx(ex_pc)] <= {1, tag(ex_pc), `ex_target`}. This overwrites on conflict.
  - If `ex_is_ctrl`=0 and the BTB entry at idx(ex_pc) is valid with matching tag: clear its valid bit (removes an aliased false hit). PHT and GHR are unchanged.
  - `mispredict_count` increments when `mispredict`=1 and wraps 0xFFFFFFFF -> 0.
- `ex_valid`=0: no state changes; `mispredict`=0.

## Timing
- Lookup and resolution are zero-latency combinational paths from registers and inputs.
- Updates become visible to lookup in the cycle after the training edge.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents.
- `reset`=1 at an edge:
  - All BTB valid bits <= 0.
  - Every PHT counter <= 2'b01 (weakly not-taken).
  - GHR <= 0.
  - `mispredict_count` <= 0.
  - Reset overrides any simultaneous update.
- Outputs after reset:
  - `pred_taken`=0, `pred_next_pc`=`if_pc`+4, `if_ghr`=0.
  - `mispredict` follows the inputs combinationally (0 when `ex_valid`=0).
- A multi-cycle reset holds all state at reset values.
- Reset asserted mid-training discards that update.

## Test plan
- After reset, `if_pc`=0x100 -> `pred_taken`=0, `pred_next_pc`=0x104, `if_ghr`=0, `mispredict_count`=0.
- EX branch `ex_pc`=0x100, `ex_taken`=1, `ex_target`=0x80, `ex_pred_pc`=0x104:
  - Same cycle: `mispredict`=1, `correct_pc`=0x80.
  - Next cycle: count=1, GHR=1.
  - Lookup of 0x100 with GHR=1 uses PHT[0^1]=01 -> not taken (0x104). After a second taken training with `ex_ghr`=1, PHT[1]=10 and GHR=3.
- With INDEX_BITS=5 and GHR held at 0: train `ex_pc`=0x100 taken twice -> PHT[0]=11. Lookup 0x100 -> `pred_next_pc`=0x80. Training not-taken twice -> prediction reverts to 0x104; a fourth not-taken saturates at 00.
- Aliasing: BTB holds 0x100->0x80. EX non-control instruction at `ex_pc`=0x100 with `ex_pred_pc`=0x80:
  - Same cycle: `mispredict`=1, `correct_pc`=0x104.
  - Next cycle: BTB entry invalid and lookup 0x100 misses.
  - Address 0x180 (same index, different tag) never hits.
- JALR target change: BTB 0x200->0x400, EX jump `ex_target`=0x500, `ex_pred_pc`=0x400 -> `mispredict`=1, `correct_pc`=0x500. The BTB entry becomes 0x500.
- Assert `reset` in the same cycle as a taken update -> no entry is written. Preload `mispredict_count` to 0xFFFFFFFF via repeated mispredicts (or force), then one more mispredict -> count wraps to 0.
